// File: rtl/armleocpu_decode_sb.sv
// Decode stage with a register-write scoreboard: classifies the fetched instruction,
// stalls on RAW hazards or scoreboard exhaustion, and holds one beat toward execute.
module armleocpu_decode_sb #(
  parameter int SB_DEPTH = 4,
  parameter int SBW      = $clog2(SB_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            f2d_valid,
  input  logic [31:0]     f2d_instr,
  input  logic [31:0]     f2d_pc,
  input  logic [3:0]      f2d_resp,
  output logic            f2d_ready,

  output logic            rs1_read,
  output logic [4:0]      rs1_raddr,
  output logic            rs2_read,
  output logic [4:0]      rs2_raddr,

  output logic            d2e_valid,
  output logic [31:0]     d2e_instr,
  output logic [31:0]     d2e_pc,
  output logic [3:0]      d2e_resp,
  output logic            d2e_rd_write,
  output logic [4:0]      d2e_rd_waddr,
  input  logic            d2e_ready,

  input  logic            flush,
  input  logic            wb_retire,

  output logic [SBW-1:0]  sb_count,
  output logic            dbg_pipeline_busy
);

  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam logic [SBW:0] DEPTH_LIM = (SBW + 1)'(SB_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [4:0] rd_field;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       writes_rd;
  logic       writes_cls;

  logic [4:0]    sb_rd [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [PW-1:0] sb_head;
  logic [PW-1:0] sb_tail;

  logic         rs1_hit;
  logic         rs2_hit;
  logic         hazard;
  logic [SBW:0] sb_need;
  logic         credit_ok;
  logic         slot_free;
  logic         accept;
  logic         sb_push;
  logic         sb_pop;

  assign opcode    = f2d_instr[6:0];
  assign rd_field  = f2d_instr[11:7];
  assign rs1_raddr = f2d_instr[19:15];
  assign rs2_raddr = f2d_instr[24:20];

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    uses_rs1   = 1'b1;
    uses_rs2   = 1'b0;
    writes_cls = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        uses_rs1   = 1'b0;
        writes_cls = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: writes_cls = 1'b1;
      OPC_BRANCH, OPC_STORE:                     uses_rs2   = 1'b1;
      OPC_OP, OPC_AMO: begin
        uses_rs2   = 1'b1;
        writes_cls = 1'b1;
      end
      default: ;
    endcase
    writes_rd = writes_cls & (rd_field != 5'd0);
    // A faulted fetch carries no real operands; it must never stall or claim a write.
    if (f2d_resp != 4'd0) begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
    end
  end

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    if (d2e_valid && d2e_rd_write) begin
      rs1_hit = (d2e_rd_waddr == rs1_raddr);
      rs2_hit = (d2e_rd_waddr == rs2_raddr);
    end
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && sb_rd[i] == rs1_raddr) rs1_hit = 1'b1;
      if (sb_valid[i] && sb_rd[i] == rs2_raddr) rs2_hit = 1'b1;
    end
    hazard = (uses_rs1 && rs1_raddr != 5'd0 && rs1_hit) ||
             (uses_rs2 && rs2_raddr != 5'd0 && rs2_hit);
  end

  // The beat sitting in d2e will claim an entry when it leaves, so reserve it now.
  assign sb_need   = {1'b0, sb_count} + {{SBW{1'b0}}, (d2e_valid & d2e_rd_write)};
  assign credit_ok = !writes_rd || (sb_need < DEPTH_LIM);
  assign slot_free = !d2e_valid || d2e_ready;
  assign accept    = !rst && f2d_valid && slot_free && !hazard && credit_ok && !flush;

  assign f2d_ready = !rst && (accept || (flush && f2d_valid));
  assign rs1_read  = accept && uses_rs1;
  assign rs2_read  = accept && uses_rs2;

  assign sb_push = d2e_valid && d2e_ready && d2e_rd_write;
  assign sb_pop  = wb_retire && (sb_count != '0);

  assign dbg_pipeline_busy = f2d_valid || d2e_valid || (sb_count != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SB_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      d2e_valid    <= 1'b0;
      d2e_rd_write <= 1'b0;
    end else if (flush) begin
      d2e_valid <= 1'b0;
    end else if (accept) begin
      d2e_valid    <= 1'b1;
      d2e_rd_write <= writes_rd;
    end else if (slot_free) begin
      d2e_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      d2e_instr    <= f2d_instr;
      d2e_pc       <= f2d_pc;
      d2e_resp     <= f2d_resp;
      d2e_rd_waddr <= rd_field;
    end
  end

  // When full, push and pop hit the same slot; the push assignment comes last and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
      sb_head  <= '0;
      sb_tail  <= '0;
      sb_count <= '0;
    end else begin
      if (sb_pop) begin
        sb_valid[sb_head] <= 1'b0;
        sb_head           <= ptr_inc(sb_head);
      end
      if (sb_push) begin
        sb_valid[sb_tail] <= 1'b1;
        sb_tail           <= ptr_inc(sb_tail);
      end
      case ({sb_push, sb_pop})
        2'b10:   sb_count <= sb_count + SBW'(1);
        2'b01:   sb_count <= sb_count - SBW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: register numbers are storage only; the valid bits alone carry reset meaning.
  always_ff @(posedge clk) begin
    if (!rst && sb_push) sb_rd[sb_tail] <= d2e_rd_waddr;
  end

endmodule
